// File: rtl/prog_loader_mem.sv
// Program loader and CPU memory: receives a length-prefixed byte image, checks it
// against a trailing XOR checksum, then releases the CPU from reset.
module prog_loader_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err
);

    localparam int DEPTH = 1 << ADDR_W;
    // Count must hold both any LEN byte value and the full depth (LEN=0).
    localparam int CNT_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;

    typedef enum logic [2:0] {
        S_LEN, S_HI, S_LO, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        hi_q;
    logic [7:0]        chk_q;
    logic              rdy_q, crst_q, done_q, err_q;

    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  len_d;
    logic [7:0]        chk_d;
    logic              accept, lo_we, cpu_wr;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        accept = byte_valid & rdy_q;
        cnt_d  = cnt_q - CNT_W'(1);
        chk_d  = chk_q ^ byte_in;
        len_d  = (byte_in == 8'h00) ? CNT_W'(DEPTH) : CNT_W'(byte_in);
        lo_we  = rst_n & accept & (state_q == S_LO);
        cpu_wr = rst_n & cpu_we & (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LEN;
            waddr_q <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            chk_q   <= '0;
            rdy_q   <= 1'b1;
            crst_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            case (state_q)
                S_LEN: begin
                    cnt_q   <= len_d;
                    waddr_q <= '0;
                    chk_q   <= '0;
                    state_q <= S_HI;
                end
                S_HI: begin
                    hi_q    <= byte_in;
                    chk_q   <= chk_d;
                    state_q <= S_LO;
                end
                S_LO: begin
                    chk_q   <= chk_d;
                    waddr_q <= waddr_q + ADDR_W'(1);
                    cnt_q   <= cnt_d;
                    state_q <= (cnt_d == '0) ? S_CHK : S_HI;
                end
                S_CHK: begin
                    rdy_q <= 1'b0;
                    if (byte_in == chk_q) begin
                        state_q <= S_DONE;
                        crst_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Loader and CPU writes never coincide: CPU writes only exist in DONE.
    always_ff @(posedge clk) begin
        if (lo_we)
            mem[waddr_q] <= DATA_W'({hi_q, byte_in});
        else if (cpu_wr)
            mem[cpu_addr] <= cpu_wdata;
    end

    assign cpu_rdata  = mem[cpu_addr];
    assign byte_ready = rdy_q;
    assign cpu_rst_n  = crst_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule
